uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, SHALL set utxi_clk cycles per serial bit; legal range 2..65535.
REQ-002 utxi_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 utxi_rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 utxi_wrn  input  1  SHALL be the active-low write strobe; a write occurs on its 0->1 transition, synchronous to utxi_clk.
REQ-005 utxi_data  input  8  SHALL be the byte to send, sampled at the write.
REQ-006 utxi_ovr_clr  input  1  SHALL clear utxo_overrun when high.
REQ-007 utxo_txd  output  1  SHALL be the serial line; idle high.
REQ-008 utxo_tbre  output  1  SHALL be high when the holding register is empty.
REQ-009 utxo_tsre  output  1  SHALL be high when the shift register is idle.
REQ-010 utxo_overrun  output  1  SHALL be a sticky flag indicating a write was dropped.

Function
REQ-011 Write detect: register utxi_wrn as wrn_q; a write SHALL be the clock edge where wrn_q=0 and utxi_wrn=1.
REQ-012 At a write with utxo_tbre=1, that same edge (E0) SHALL load utxi_data into the holding register and drive utxo_tbre to 0.
REQ-013 At a write with utxo_tbre=0, the data SHALL be discarded, the holding register SHALL be unchanged, and utxo_overrun SHALL be set to 1.
REQ-014 FSM states: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
REQ-015 In IDLE with the holding register full, the next edge (E1) SHALL:
- move holding to the shift register;
- set utxo_tbre=1 and utxo_tsre=0;
- drive utxo_txd=0;
- enter START.
REQ-016 Each of START, each DATA bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter counting CLKS_PER_BIT-1 down to 0 and reloading.
REQ-017 DATA SHALL send 8 bits LSB first, tracked by a 3-bit index; after bit 7 the FSM SHALL go to PARITY or STOP. STOP SHALL drive utxo_txd=1.
REQ-018 At the end of STOP with the holding register full, the FSM SHALL transfer as in REQ-015 and go directly to START with no idle bit. With the holding register empty, it SHALL go to IDLE and set utxo_tsre=1.
REQ-019 A write on the same edge as a holding->shift transfer SHALL be judged against utxo_tbre before that edge, so it counts as overrun.
REQ-020 utxi_ovr_clr SHALL clear utxo_overrun. If a clear and a new overrun occur on the same edge, the set SHALL win.
REQ-021 Frame length SHALL be 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT cycles with parity.

Reset
REQ-022 While utxi_rst=1, the block SHALL hold:
- utxo_txd=1, utxo_tbre=1, utxo_tsre=1, utxo_overrun=0;
- FSM=IDLE, baud counter=0, bit index=0;
- holding register empty, wrn_q=1.
REQ-023 Reset mid-frame SHALL abort the frame immediately (utxo_txd=1 asynchronously). Deasserting reset while utxi_wrn=0 SHALL NOT itself create a write unless utxi_wrn later rises.

Configuration
REQ-024 When macro UART_TX_PARITY_EN is defined, the block SHALL insert an even-parity bit (XOR of the 8 data bits) after bit 7, in state PARITY.
REQ-025 When UART_TX_PARITY_EN is undefined, the PARITY state and its logic SHALL be absent, and frames SHALL be 8N1.

Verification (CLKS_PER_BIT=4)
REQ-026 Single byte:
- Stimulus: write 0x55 while idle.
- Response: tbre falls at E0; at E1 tbre rises and tsre falls; txd is 0,1,0,1,0,1,0,1,0,1, each held for 4 cycles; tsre rises 40 cycles after E1.
REQ-027 Back-to-back:
- Stimulus: write 0xA5, then write 0x3C while the 0xA5 frame is in DATA.
- Response: the 0x3C start bit follows the 0xA5 stop bit with no high gap; tsre stays 0 for 80 cycles.
REQ-028 Overrun:
- Stimulus: write 0x11, 0x22 and 0x33 within 3 cycles of each other.
- Response: 0x11 and 0x22 are transmitted and 0x33 is dropped; utxo_overrun=1 until utxi_ovr_clr is pulsed, then 0.
REQ-029 Reset mid-frame:
- Stimulus: assert utxi_rst during DATA bit 3 of 0xF0.
- Response: txd=1, tbre=1, tsre=1 immediately; after release, writing 0x81 produces a clean frame.
REQ-030 Parity (UART_TX_PARITY_EN defined):
- Stimulus: write 0x07.
- Response: the parity bit is 1 and the frame is 44 cycles.
- Stimulus: write 0x03.
- Response: the parity bit is 0.
REQ-031 Held strobe:
- Stimulus: hold utxi_wrn=0 for 20 cycles, then release.
- Response: exactly one write occurs, on the release edge.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if: write-side strobe/data and line/status bundle for uart_tx.
// master drives wrn/data/ovr_clr; slave (the UART) drives txd and flags.
interface uart_tx_if;
  logic       utxi_wrn;
  logic [7:0] utxi_data;
  logic       utxi_ovr_clr;
  logic       utxo_txd;
  logic       utxo_tbre;
  logic       utxo_tsre;
  logic       utxo_overrun;

  modport master (
    output utxi_wrn,
    output utxi_data,
    output utxi_ovr_clr,
    input  utxo_txd,
    input  utxo_tbre,
    input  utxo_tsre,
    input  utxo_overrun
  );

  modport slave (
    input  utxi_wrn,
    input  utxi_data,
    input  utxi_ovr_clr,
    output utxo_txd,
    output utxo_tbre,
    output utxo_tsre,
    output utxo_overrun
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: double-buffered 8N1 UART transmitter (holding + shift register).
// Ports: utxi_clk, utxi_rst (async, active-high), bus (uart_tx_if.slave):
//   utxi_wrn write strobe (write on 0->1), utxi_data byte, utxi_ovr_clr,
//   utxo_txd serial line, utxo_tbre/utxo_tsre empty flags, utxo_overrun.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic     utxi_clk,
  input  logic     utxi_rst,
  uart_tx_if.slave bus
);

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        tsre_q, tsre_d;
  logic [7:0]  hold_q;
  logic        hold_full;
  logic        wrn_q;
  logic        ovr_q;

  logic tick;
  logic write;
  logic xfer;

  assign tick  = (cnt_q == 16'd0);
  assign write = ~wrn_q & bus.utxi_wrn;
  // Holding->shift move: straight from idle, or back-to-back at stop end.
  assign xfer  = hold_full &
                 ((state_q == S_IDLE) |
                  ((state_q == S_STOP) & tick));

  always_ff @(posedge utxi_clk or posedge utxi_rst) begin
    if (utxi_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (hold_full) state_d = S_START;
      S_START: if (tick) state_d = S_DATA;
      S_DATA: begin
        if (tick && idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (tick) state_d = S_STOP;
`endif
      S_STOP: begin
        if (tick) state_d = hold_full ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    txd_d   = txd_q;
    tsre_d  = tsre_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = tick ? BAUD_MAX : cnt_q - 16'd1;
    if (state_q == S_IDLE) cnt_d = '0;
    if (xfer) begin
      shift_d = hold_q;
      txd_d   = 1'b0;
      tsre_d  = 1'b0;
      idx_d   = '0;
      cnt_d   = BAUD_MAX;
    end else if (tick) begin
      unique case (state_q)
        S_START: begin
          txd_d = shift_q[0];
          idx_d = '0;
        end
        S_DATA: begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_d = ^shift_q;
`else
            txd_d = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = shift_q[idx_q + 3'd1];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: txd_d = 1'b1;
`endif
        S_STOP: begin
          txd_d  = 1'b1;
          tsre_d = 1'b1;
          cnt_d  = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge utxi_clk or posedge utxi_rst) begin
    if (utxi_rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      tsre_q    <= 1'b1;
      hold_q    <= '0;
      hold_full <= 1'b0;
      wrn_q     <= 1'b1;
      ovr_q     <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      tsre_q  <= tsre_d;
      wrn_q   <= bus.utxi_wrn;
      // A write is judged against the pre-edge flag, so a write that
      // coincides with a transfer is dropped as an overrun.
      if (xfer) hold_full <= 1'b0;
      if (write && !hold_full) begin
        hold_q    <= bus.utxi_data;
        hold_full <= 1'b1;
      end
      if (write && hold_full)  ovr_q <= 1'b1;
      else if (bus.utxi_ovr_clr) ovr_q <= 1'b0;
    end
  end

  assign bus.utxo_txd     = txd_q;
  assign bus.utxo_tbre    = ~hold_full;
  assign bus.utxo_tsre    = tsre_q;
  assign bus.utxo_overrun = ovr_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx with CLKS_PER_BIT=4.
// Table of single frames plus overrun, back-to-back, reset, held strobe.
module tb_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if bus();

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .utxi_clk(clk),
    .utxi_rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [10:0] mkf(
    input logic [9:0] f, input logic p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, f[8:0]};
`else
    return {p & 1'b0, f};
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] d);
    bus.utxi_data = d;
    bus.utxi_wrn  = 1'b0;
    step();
    bus.utxi_wrn  = 1'b1;
    step();
  endtask

  task automatic capture(input int nb,
                         output logic [31:0] f,
                         output int unst,
                         output int thi);
    f = '0;
    unst = 0;
    thi = 0;
    for (int i = 0; i < nb * CPB; i++) begin
      if (i % CPB == 0) f[i / CPB] = bus.utxo_txd;
      else if (bus.utxo_txd !== f[i / CPB]) unst++;
      if (bus.utxo_tsre !== 1'b0) thi++;
      step();
    end
  endtask

  task automatic run_frame(input string nm,
                           input logic [10:0] exp);
    logic [31:0] f;
    int u, t;
    chk({nm, " tbre@E0"}, 32'(bus.utxo_tbre), 32'd0);
    chk({nm, " tsre@E0"}, 32'(bus.utxo_tsre), 32'd1);
    step();
    chk({nm, " tbre@E1"}, 32'(bus.utxo_tbre), 32'd1);
    chk({nm, " tsre@E1"}, 32'(bus.utxo_tsre), 32'd0);
    chk({nm, " start"}, 32'(bus.utxo_txd), 32'd0);
    capture(FB, f, u, t);
    chk({nm, " frame"}, f, 32'(exp));
    chk({nm, " stable"}, 32'(u), 32'd0);
    chk({nm, " tsre busy"}, 32'(t), 32'd0);
    chk({nm, " tsre end"}, 32'(bus.utxo_tsre), 32'd1);
    chk({nm, " txd idle"}, 32'(bus.utxo_txd), 32'd1);
  endtask

  initial begin
    logic [31:0] f;
    logic [31:0] e;
    int u, t, bad;

    bus.utxi_wrn     = 1'b1;
    bus.utxi_data    = 8'h00;
    bus.utxi_ovr_clr = 1'b0;

    vecs[0] = '{8'h55, 10'b1_01010101_0, 1'b0};
    vecs[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[3] = '{8'h07, 10'b1_00000111_0, 1'b1};
    vecs[4] = '{8'h03, 10'b1_00000011_0, 1'b0};
    vecs[5] = '{8'h80, 10'b1_10000000_0, 1'b1};

    step();
    step();
    chk("rst txd", 32'(bus.utxo_txd), 32'd1);
    chk("rst tbre", 32'(bus.utxo_tbre), 32'd1);
    chk("rst tsre", 32'(bus.utxo_tsre), 32'd1);
    chk("rst ovr", 32'(bus.utxo_overrun), 32'd0);
    rst = 1'b0;
    step();
    step();

    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].data);
      run_frame($sformatf("vec%0d", i),
                mkf(vecs[i].frame, vecs[i].par));
      step();
      step();
    end

    // Overrun: 0x11, 0x22, 0x33 two cycles apart; clear on the set edge.
    do_write(8'h11);
    step();
    chk("ovr tsre@E1", 32'(bus.utxo_tsre), 32'd0);
    fork
      begin
        do_write(8'h22);
        bus.utxi_data = 8'h33;
        bus.utxi_wrn  = 1'b0;
        step();
        bus.utxi_wrn     = 1'b1;
        bus.utxi_ovr_clr = 1'b1;
        step();
        bus.utxi_ovr_clr = 1'b0;
        chk("ovr set wins", 32'(bus.utxo_overrun), 32'd1);
      end
      capture(2 * FB, f, u, t);
    join
    e = (32'(mkf(10'b1_00100010_0, 1'b0)) << FB) |
        32'(mkf(10'b1_00010001_0, 1'b0));
    chk("ovr frames", f, e);
    chk("ovr stable", 32'(u), 32'd0);
    chk("ovr tsre busy", 32'(t), 32'd0);
    chk("ovr tsre end", 32'(bus.utxo_tsre), 32'd1);
    repeat (3) step();
    chk("ovr sticky", 32'(bus.utxo_overrun), 32'd1);
    bus.utxi_ovr_clr = 1'b1;
    step();
    bus.utxi_ovr_clr = 1'b0;
    chk("ovr clr", 32'(bus.utxo_overrun), 32'd0);

    // Back-to-back: 0x3C during 0xA5 DATA; 0x99 on the transfer edge.
    do_write(8'hA5);
    step();
    fork
      begin
        repeat (8) step();
        do_write(8'h3C);
        repeat (FB * CPB - 12) step();
        do_write(8'h99);
      end
      capture(2 * FB, f, u, t);
    join
    e = (32'(mkf(10'b1_00111100_0, 1'b0)) << FB) |
        32'(mkf(10'b1_10100101_0, 1'b0));
    chk("b2b frames", f, e);
    chk("b2b stable", 32'(u), 32'd0);
    chk("b2b tsre busy", 32'(t), 32'd0);
    chk("b2b tsre end", 32'(bus.utxo_tsre), 32'd1);
    chk("b2b tbre end", 32'(bus.utxo_tbre), 32'd1);
    chk("b2b xfer ovr", 32'(bus.utxo_overrun), 32'd1);
    bus.utxi_ovr_clr = 1'b1;
    step();
    bus.utxi_ovr_clr = 1'b0;
    step();

    // Reset during DATA bit 3 of 0xF0, strobe held low across release.
    do_write(8'hF0);
    step();
    repeat (16) step();
    chk("rstmid bit3", 32'(bus.utxo_txd), 32'd0);
    chk("rstmid tsre", 32'(bus.utxo_tsre), 32'd0);
    rst = 1'b1;
    bus.utxi_wrn  = 1'b0;
    bus.utxi_data = 8'h81;
    #1;
    chk("rstmid txd", 32'(bus.utxo_txd), 32'd1);
    chk("rstmid tbre", 32'(bus.utxo_tbre), 32'd1);
    chk("rstmid tsre1", 32'(bus.utxo_tsre), 32'd1);
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk("rel no write", 32'(bus.utxo_tbre), 32'd1);
    chk("rel tsre", 32'(bus.utxo_tsre), 32'd1);
    bus.utxi_wrn = 1'b1;
    step();
    run_frame("post rst", mkf(10'b1_10000001_0, 1'b0));
    step();

    // Held strobe: 20 cycles low, one write on release.
    bus.utxi_data = 8'hC3;
    bus.utxi_wrn  = 1'b0;
    bad = 0;
    repeat (20) begin
      step();
      if (bus.utxo_tbre !== 1'b1) bad++;
    end
    chk("held no write", 32'(bad), 32'd0);
    bus.utxi_wrn = 1'b1;
    step();
    run_frame("held", mkf(10'b1_11000011_0, 1'b0));
    repeat (3) step();
    chk("held single", 32'(bus.utxo_tsre), 32'd1);
    chk("held tbre", 32'(bus.utxo_tbre), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
